// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and constants for the cdc_tx/cdc_rx clock-domain crossing pair
package cdc_pkg;
  typedef enum logic {RX_IDLE, RX_ACK} cdc_rx_state_e;
  localparam int CDC_SYNC_DP_DEFAULT = 2;
  localparam int CDC_SYNC_DP_MIN     = 2;
endpackage

// File: rtl/cdc_sync.sv
// cdc_sync: SYNC_DP-deep single-bit synchronizer, async active-low reset, no logic between stages
module cdc_sync
  import cdc_pkg::*;
#(
  parameter int SYNC_DP = CDC_SYNC_DP_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_DP-1:0] sync_q;
  if (SYNC_DP < CDC_SYNC_DP_MIN) begin : g_bad_depth
    $error("cdc_sync: SYNC_DP below minimum synchronizer depth");
  end
  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_DP-2:0], d_i};
  end
  assign q_o = sync_q[SYNC_DP-1];
endmodule

// File: rtl/cdc_rx.sv
// cdc_rx: 4-phase request/ack receiver re-issuing words on a valid/ready port.
// Optional CDC_RX_SKID_EN turns the single output register into a 2-entry in-order FIFO.
module cdc_rx
  import cdc_pkg::*;
#(
  parameter int DW      = 32,
  parameter int SYNC_DP = CDC_SYNC_DP_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);
  cdc_rx_state_e state_q, state_d;
  logic vld_sync, buf_free, capture;

  cdc_sync #(.SYNC_DP(SYNC_DP)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (i_vld),
    .q_o   (vld_sync)
  );

  // i_dat is stable while vld_sync is high, so it is captured without synchronization
  assign capture = (state_q == RX_IDLE) & vld_sync & buf_free;
  assign i_rdy   = (state_q == RX_ACK);

  // advance to RX_ACK on capture, back to RX_IDLE once the request drops
  always_comb begin
    state_d = state_q;
    if (state_q == RX_IDLE) state_d = capture ? RX_ACK : RX_IDLE;
    else                    state_d = vld_sync ? RX_ACK : RX_IDLE;
  end

  // state register; its output is the glitch-free acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

`ifdef CDC_RX_SKID_EN
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
  logic          pop;

  assign pop      = (cnt_q != 2'd0) & o_rdy;
  assign buf_free = (cnt_q != 2'd2) | pop;
  assign o_vld    = (cnt_q != 2'd0);
  assign o_dat    = e0_q;

  // e0 is the head; a pop shifts e1 forward, a push fills the first free slot
  always_comb begin
    cnt_d = cnt_q + 2'(capture) - 2'(pop);
    e0_d  = (pop & (cnt_q == 2'd2)) ? e1_q :
            (capture & ((cnt_q == 2'd0) | (pop & (cnt_q == 2'd1)))) ? i_dat : e0_q;
    e1_d  = (capture & (((cnt_q == 2'd1) & ~pop) | ((cnt_q == 2'd2) & pop))) ? i_dat : e1_q;
  end

  // FIFO storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end
`else
  logic          o_vld_q, o_vld_d;
  logic [DW-1:0] o_dat_q, o_dat_d;

  assign buf_free = ~o_vld_q | o_rdy;
  assign o_vld    = o_vld_q;
  assign o_dat    = o_dat_q;

  // capture wins over drain so a same-cycle refill keeps o_vld high
  always_comb begin
    o_vld_d = capture | (o_vld_q & ~o_rdy);
    o_dat_d = capture ? i_dat : o_dat_q;
  end

  // single-entry output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld_q <= 1'b0;
      o_dat_q <= '0;
    end else begin
      o_vld_q <= o_vld_d;
      o_dat_q <= o_dat_d;
    end
  end
`endif
endmodule

// File: doc/cdc_rx.md
Name: cdc_rx

Overview:
- Receive half of the clock-domain crossing. It sits directly downstream of cdc_tx, in the destination clock domain.
- Consumes the 4-phase request/acknowledge (i_vld/i_rdy) plus the held data bus driven by cdc_tx.
- Re-issues each word on a regular valid/ready handshake (o_vld/o_rdy, AXI-like) to local logic.
- Exactly one output word per completed 4-phase transaction; no loss, no duplication.

Parameters:
- DW, 32, data width; must match the paired cdc_tx.
- SYNC_DP, 2, synchronizer depth on i_vld; legal range >= 2.

Ports:
- clk  input  1  destination-domain clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_vld  input  1  4-phase request from cdc_tx, asynchronous to clk.
- i_rdy  output  1  4-phase acknowledge to cdc_tx; registered, glitch-free.
- i_dat  input  DW  data from cdc_tx; stable from before i_vld rises until after i_rdy falls.
- o_vld  output  1  output word valid.
- o_rdy  input  1  downstream ready.
- o_dat  output  DW  output word.

Behaviour:
- Reset: all flops cleared asynchronously. i_rdy=0, o_vld=0, o_dat=0, FSM in RX_IDLE, sync chain=0.
- Synchronizer: i_vld passes through SYNC_DP flops, giving vld_sync. No logic is placed between synchronizer stages.
- i_dat is never synchronized. It is sampled only when vld_sync=1, which is safe because of the cdc_tx hold rule.
- buf_free = (~o_vld) | o_rdy. An entry is free, or drained this cycle.
- FSM RX_IDLE, i_rdy=0:
  - if vld_sync & buf_free: go to RX_ACK, load o_dat<=i_dat, set o_vld.
  - otherwise stay. A pending request waits with no timeout.
- FSM RX_ACK, i_rdy=1:
  - if ~vld_sync: go to RX_IDLE.
  - no capture occurs in RX_ACK.
- i_rdy is a registered decode of the state: 1 in RX_ACK, 0 in RX_IDLE.
- o_vld:
  - set on capture; cleared on o_vld&o_rdy unless a capture occurs in the same cycle.
  - capture together with drain: o_vld stays 1 and o_dat takes the new word.
  - once asserted, o_vld and o_dat hold until o_rdy.
- Latency, with i_vld meeting setup:
  - i_vld rise -> o_vld=1 and i_rdy=1 after SYNC_DP+1 clk edges.
  - i_vld fall -> i_rdy=0 after SYNC_DP+1 edges.
- Backpressure: with o_vld=1 and o_rdy=0, i_rdy stays low. cdc_tx therefore stalls with i_vld high, and no data is lost.
- Throughput bound: one word per full 4-phase round trip. The buffer is never the bottleneck when o_rdy=1.
- Reset mid-transaction: rx returns to RX_IDLE with the buffer cleared. If i_vld is still high after reset, the word is accepted again. Both sides must therefore share a reset event; this is a system-level rule.
- An i_vld pulse shorter than one clk period is a protocol violation. Behaviour is undefined, but it must not hang the FSM.

Optional Feature:
- CDC_RX_SKID_EN defined:
  - output buffer becomes a 2-entry FIFO (head drives o_dat/o_vld); buf_free = FIFO not full, or head popped this cycle.
  - a second transaction can complete while the first word is stalled by o_rdy=0.
  - words leave in order; a simultaneous push and pop on a full FIFO is legal.
- Not defined: single-entry buffer exactly as above. Ports and reset values are identical in both builds.

Decomposition:
- Package cdc_pkg holds:
  - typedef enum logic {RX_IDLE, RX_ACK} cdc_rx_state_e;
  - constant CDC_SYNC_DP_DEFAULT=2 (shared with cdc_tx);
  - constant CDC_SYNC_DP_MIN=2, used by an elaboration-time check.
- Natural sub-module: cdc_sync, a parameterized SYNC_DP-deep single-bit synchronizer with async active-low reset, reusable by cdc_tx.

Test Plan (DW=32, SYNC_DP=2, async source clock ratio 1.7:1):
- Single word 0xDEADBEEF, o_rdy=1:
  - o_vld=1, o_dat=0xDEADBEEF on the 3rd clk edge after i_vld rise;
  - i_rdy rises with it and falls 3 edges after i_vld falls;
  - exactly one beat.
- Backpressure: send 0x1 with o_rdy=0, then raise i_vld for 0x2:
  - i_rdy stays 0 for 0x2 until 0x1 is popped;
  - output order 0x1, 0x2; no drops.
- Back-to-back, cdc_tx paired, 1000 random words, random o_rdy:
  - scoreboard matches in order;
  - no duplicate; o_dat stable while o_vld & ~o_rdy.
- Drain and capture in the same cycle (o_vld=1, o_rdy=1, vld_sync rising):
  - o_vld stays 1; o_dat updates to the new word next cycle.
- Reset asserted in RX_ACK:
  - i_rdy, o_vld, o_dat go to 0 immediately (async);
  - after release with i_vld still high, one re-accept occurs.
- CDC_RX_SKID_EN, o_rdy=0, two transactions 0xA, 0xB:
  - both 4-phase cycles complete; third i_rdy held 0;
  - output order 0xA, 0xB once o_rdy=1.
